// File: rtl/exec_pkg.sv
// Shared definitions for the Execute-stage multiply sequencer.
package exec_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath: operand/product/count registers and one add-shift step per cycle.
module mul_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 clear_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 last_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mplier_shr;

  // The current step is the final one when the count is exhausted or no multiplier bits remain.
  assign mplier_shr = mplier_q >> 1;
  assign last_o     = (count_q == CW'(WIDTH - 1)) || (mplier_shr == '0);
  assign product_o  = product_q;

  // Next-state for load, add-shift step and discard.
  always_comb begin
    mcand_d   = mcand_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    if (clear_i) begin
      mcand_d   = '0;
      product_d = '0;
      mplier_d  = '0;
      count_d   = '0;
    end else if (load_i) begin
      mcand_d   = PW'(mcand_i);
      product_d = '0;
      mplier_d  = mplier_i;
      count_d   = '0;
    end else if (step_i) begin
      product_d = product_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d   = mcand_q << 1;
      mplier_d  = mplier_shr;
      count_d   = count_q + CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q   <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
    end else begin
      mcand_q   <= mcand_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/exec_mul_sequencer.sv
// Multi-cycle unsigned multiply sequencer beside Execute: stalls F/D/E and strobes the result into E->M.
module exec_mul_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Mul_start_E,
  input  logic                 Mul_hi_E,
  input  logic [WIDTH-1:0]     SrcA_E,
  input  logic [WIDTH-1:0]     SrcB_E,
  input  logic [REG_IDX_W-1:0] RD_E,
  input  logic                 Flush,
  output logic                 Stall,
  output logic                 Busy,
  output logic                 Mul_valid_M,
  output logic [WIDTH-1:0]     Mul_out_M,
  output logic [REG_IDX_W-1:0] RD_mul_M
);

  mul_state_e           state_q, state_d;
  logic                 hi_q, hi_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 dp_load, dp_step, dp_clear, dp_last;
  logic [2*WIDTH-1:0]   product;

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .clear_i  (dp_clear),
    .mcand_i  (SrcA_E),
    .mplier_i (SrcB_E),
    .product_o(product),
    .last_o   (dp_last)
  );

  // Next-state, datapath controls and the same-cycle Stall/valid decode.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    rd_d        = rd_q;
    dp_load     = 1'b0;
    dp_step     = 1'b0;
    dp_clear    = 1'b0;
    Stall       = 1'b0;
    Mul_valid_M = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Mul_start_E && !Flush) begin
          state_d = ST_RUN;
          hi_d    = Mul_hi_E;
          rd_d    = RD_E;
          dp_load = 1'b1;
          Stall   = 1'b1;
        end
      end
      ST_RUN: begin
        if (Flush) begin
          state_d  = ST_IDLE;
          dp_clear = 1'b1;
        end else begin
          dp_step = 1'b1;
          Stall   = 1'b1;
          if (dp_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Start is ignored here: the same multiply is still sitting in E.
        state_d     = ST_IDLE;
        dp_clear    = 1'b1;
        Mul_valid_M = !Flush;
      end
      default: state_d = ST_IDLE;
    endcase
    // Start can be high while reset is held; keep the pipeline free during reset.
    if (!rst) Stall = 1'b0;
  end

  // Result muxing toward the E->M register; zero unless strobing.
  assign Mul_out_M = Mul_valid_M ? (hi_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0]) : '0;
  assign RD_mul_M  = Mul_valid_M ? rd_q : '0;
  assign Busy      = (state_q != ST_IDLE);

  // FSM state and latched instruction fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hi_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      rd_q    <= rd_d;
    end
  end

endmodule
